// File: rtl/cnn_seq_ctrl.sv
// ---------------------------------------------------------------------------
// cnn_seq_ctrl
//
// Frame sequencer for the CNN layer pipeline (conv, pool, conv, pool, dense).
// A host start request launches stage 0. Each stage's ready pulse launches
// the next stage. After the last stage reports ready, the sequencer waits
// for the UART to finish sending the result byte and then signals completion.
// A per-stage watchdog moves the sequencer to an error state if a stage, or
// the transmitter, stalls.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   strt      in   frame start request (single-cycle pulse)
//   abort     in   synchronous abort, returns to idle
//   stg_rdy   in   [NUM_STG] per-stage ready pulses
//   tx_done   in   UART finished sending the result byte
//   stg_strt  out  [NUM_STG] one-hot, single-cycle stage start pulses
//   bsy       out  frame in progress
//   done      out  one-cycle frame-complete pulse
//   err_tmo   out  sticky watchdog timeout flag
//   err_spur  out  sticky flag: ready pulse from a stage that is not running
//   cur_stg   out  [STG_W] index of the running (or failed) stage
//   frm_cnt   out  [8] completed-frame counter, wraps at 256
//
// Every output is a register. The two combinational processes only compute
// next-state values, so no input reaches an output in the same cycle.
// ---------------------------------------------------------------------------
module cnn_seq_ctrl #(
  parameter int NUM_STG = 5,
  parameter int TMO_CYC = 1000000,
  parameter int STG_W   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               strt,
  input  logic               abort,
  input  logic [NUM_STG-1:0] stg_rdy,
  input  logic               tx_done,
  output logic [NUM_STG-1:0] stg_strt,
  output logic               bsy,
  output logic               done,
  output logic               err_tmo,
  output logic               err_spur,
  output logic [STG_W-1:0]   cur_stg,
  output logic [7:0]         frm_cnt
);

  // The watchdog counts 0 .. TMO_CYC-1. For TMO_CYC >= 2, $clog2 gives
  // enough bits to hold TMO_CYC-1.
  localparam int                 WDG_W    = $clog2(TMO_CYC);
  localparam logic [WDG_W-1:0]   WDG_MAX  = WDG_W'(TMO_CYC - 1);
  localparam logic [STG_W-1:0]   LAST_STG = STG_W'(NUM_STG - 1);
  localparam logic [NUM_STG-1:0] STG0_OH  = NUM_STG'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_WAIT_TX,
    S_ERR
  } state_t;

  state_t state, state_nxt;

  logic [WDG_W-1:0]   wdg, wdg_nxt;
  logic [NUM_STG-1:0] stg_strt_nxt;
  logic               bsy_nxt;
  logic               done_nxt;
  logic               err_tmo_nxt;
  logic               err_spur_nxt;
  logic [STG_W-1:0]   cur_stg_nxt;
  logic [7:0]         frm_cnt_nxt;

  // Decode the ready vector against the running stage. A one-hot mask is
  // used instead of indexing so that the unused index codes above
  // NUM_STG-1 never select anything.
  logic [NUM_STG-1:0] cur_oh;
  logic               rdy_cur;
  logic               rdy_oth;
  logic               rdy_any;
  logic               wdg_exp;

  assign cur_oh  = STG0_OH << cur_stg;
  assign rdy_cur = |(stg_rdy & cur_oh);
  assign rdy_oth = |(stg_rdy & ~cur_oh);
  assign rdy_any = |stg_rdy;
  assign wdg_exp = (wdg == WDG_MAX);

  // -------------------------------------------------------------------------
  // State register and output registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) assignments. All registers
  // then update together from values sampled before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wdg      <= '0;
      stg_strt <= '0;
      bsy      <= 1'b0;
      done     <= 1'b0;
      err_tmo  <= 1'b0;
      err_spur <= 1'b0;
      cur_stg  <= '0;
      frm_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      wdg      <= wdg_nxt;
      stg_strt <= stg_strt_nxt;
      bsy      <= bsy_nxt;
      done     <= done_nxt;
      err_tmo  <= err_tmo_nxt;
      err_spur <= err_spur_nxt;
      cur_stg  <= cur_stg_nxt;
      frm_cnt  <= frm_cnt_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: each variable written in always_comb receives a default value
  // first. Any path that does not assign it therefore cannot infer a latch.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (strt) state_nxt = S_RUN;
        end
        S_RUN: begin
          // A valid ready in the expiry cycle takes priority over the timeout.
          if (rdy_cur) begin
            if (cur_stg == LAST_STG) state_nxt = S_WAIT_TX;
          end else if (wdg_exp) begin
            state_nxt = S_ERR;
          end
        end
        S_WAIT_TX: begin
          if (tx_done)      state_nxt = S_IDLE;
          else if (wdg_exp) state_nxt = S_ERR;
        end
        S_ERR: begin
          if (strt) state_nxt = S_RUN;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output logic (next values of the registered outputs)
  // -------------------------------------------------------------------------
  always_comb begin
    stg_strt_nxt = '0;
    done_nxt     = 1'b0;
    bsy_nxt      = (state_nxt == S_RUN) || (state_nxt == S_WAIT_TX);
    wdg_nxt      = wdg;
    err_tmo_nxt  = err_tmo;
    err_spur_nxt = err_spur;
    cur_stg_nxt  = cur_stg;
    frm_cnt_nxt  = frm_cnt;

    // Spurious ready detection. Apart from setting this flag, a spurious
    // ready is ignored. A frame start below overrides the flag and clears it.
    if (((state == S_RUN) && rdy_oth) ||
        (((state == S_IDLE) || (state == S_WAIT_TX)) && rdy_any)) begin
      err_spur_nxt = 1'b1;
    end

    if (abort) begin
      cur_stg_nxt = '0;
      wdg_nxt     = '0;
    end else begin
      unique case (state)
        S_IDLE, S_ERR: begin
          if (strt) begin
            stg_strt_nxt = STG0_OH;
            cur_stg_nxt  = '0;
            wdg_nxt      = '0;
            err_tmo_nxt  = 1'b0;
            err_spur_nxt = 1'b0;
          end
        end
        S_RUN: begin
          if (rdy_cur) begin
            wdg_nxt = '0;
            if (cur_stg != LAST_STG) begin
              stg_strt_nxt = cur_oh << 1;
              cur_stg_nxt  = cur_stg + STG_W'(1);
            end
          end else if (wdg_exp) begin
            err_tmo_nxt = 1'b1;
          end else begin
            wdg_nxt = wdg + WDG_W'(1);
          end
        end
        S_WAIT_TX: begin
          if (tx_done) begin
            done_nxt    = 1'b1;
            frm_cnt_nxt = frm_cnt + 8'd1;
            cur_stg_nxt = '0;
            wdg_nxt     = '0;
          end else if (wdg_exp) begin
            // cur_stg stays at the last stage to show where the stall was.
            err_tmo_nxt = 1'b1;
          end else begin
            wdg_nxt = wdg + WDG_W'(1);
          end
        end
        default: begin
          cur_stg_nxt = '0;
          wdg_nxt     = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cnn_seq_ctrl
//
// Directed bench for cnn_seq_ctrl with NUM_STG=5 and TMO_CYC=100.
// Inputs are driven at the falling edge and sampled by the next rising edge.
// Outputs are checked at the following falling edge.
// ---------------------------------------------------------------------------
module tb_cnn_seq_ctrl;

  localparam int NUM_STG = 5;
  localparam int TMO_CYC = 100;
  localparam int STG_W   = 3;

  logic               clk;
  logic               rst_n;
  logic               strt;
  logic               abort;
  logic [NUM_STG-1:0] stg_rdy;
  logic               tx_done;
  logic [NUM_STG-1:0] stg_strt;
  logic               bsy;
  logic               done;
  logic               err_tmo;
  logic               err_spur;
  logic [STG_W-1:0]   cur_stg;
  logic [7:0]         frm_cnt;

  int n_chk = 0;
  int n_err = 0;

  cnn_seq_ctrl #(
    .NUM_STG(NUM_STG),
    .TMO_CYC(TMO_CYC),
    .STG_W  (STG_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .strt    (strt),
    .abort   (abort),
    .stg_rdy (stg_rdy),
    .tx_done (tx_done),
    .stg_strt(stg_strt),
    .bsy     (bsy),
    .done    (done),
    .err_tmo (err_tmo),
    .err_spur(err_spur),
    .cur_stg (cur_stg),
    .frm_cnt (frm_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         s;
    logic         a;
    logic [4:0]   r;
    logic         t;
    logic [4:0]   e_strt;
    logic         e_bsy;
    logic         e_done;
    logic         e_tmo;
    logic         e_spur;
    logic [2:0]   e_cur;
    logic [7:0]   e_frm;
  } vec_t;

  vec_t tbl [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [4:0] e_strt, input logic e_bsy,
                           input logic e_done, input logic e_tmo, input logic e_spur,
                           input logic [2:0] e_cur, input logic [7:0] e_frm);
    check({tag, ".stg_strt"}, 32'(stg_strt), 32'(e_strt));
    check({tag, ".bsy"},      32'(bsy),      32'(e_bsy));
    check({tag, ".done"},     32'(done),     32'(e_done));
    check({tag, ".err_tmo"},  32'(err_tmo),  32'(e_tmo));
    check({tag, ".err_spur"}, 32'(err_spur), 32'(e_spur));
    check({tag, ".cur_stg"},  32'(cur_stg),  32'(e_cur));
    check({tag, ".frm_cnt"},  32'(frm_cnt),  32'(e_frm));
  endtask

  // Drive one cycle's inputs, let a rising edge sample them, return at the
  // next falling edge with all inputs deasserted again.
  task automatic step(input logic s, input logic a, input logic [4:0] r, input logic t);
    strt    = s;
    abort   = a;
    stg_rdy = r;
    tx_done = t;
    @(negedge clk);
    strt    = 1'b0;
    abort   = 1'b0;
    stg_rdy = '0;
    tx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  // Start a frame and return each stage ready immediately. The sequencer is
  // left in WAIT_TX.
  task automatic fast_to_wait_tx();
    step(1'b1, 1'b0, 5'd0, 1'b0);
    for (int k = 0; k < NUM_STG; k++) step(1'b0, 1'b0, 5'(1 << k), 1'b0);
  endtask

  // Global bound on run time.
  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "simulation time limit exceeded");
  end

  initial begin
    // Table rows: {strt, abort, stg_rdy, tx_done} ->
    //             {stg_strt, bsy, done, err_tmo, err_spur, cur_stg, frm_cnt}
    tbl[0]  = '{1'b0, 1'b0, 5'h00, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0};
    tbl[1]  = '{1'b0, 1'b0, 5'h00, 1'b1, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0};
    tbl[2]  = '{1'b1, 1'b0, 5'h00, 1'b0, 5'h01, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0};
    tbl[3]  = '{1'b0, 1'b0, 5'h00, 1'b0, 5'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0};
    tbl[4]  = '{1'b0, 1'b0, 5'h01, 1'b0, 5'h02, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 8'd0};
    tbl[5]  = '{1'b0, 1'b0, 5'h08, 1'b0, 5'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 8'd0};
    tbl[6]  = '{1'b1, 1'b0, 5'h02, 1'b0, 5'h04, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 8'd0};
    tbl[7]  = '{1'b0, 1'b0, 5'h05, 1'b0, 5'h08, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 8'd0};
    tbl[8]  = '{1'b0, 1'b0, 5'h08, 1'b1, 5'h10, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 8'd0};
    tbl[9]  = '{1'b0, 1'b0, 5'h10, 1'b0, 5'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 8'd0};
    tbl[10] = '{1'b0, 1'b0, 5'h00, 1'b1, 5'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 8'd1};
    tbl[11] = '{1'b0, 1'b0, 5'h00, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'd1};
    tbl[12] = '{1'b1, 1'b0, 5'h00, 1'b0, 5'h01, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd1};
    tbl[13] = '{1'b0, 1'b1, 5'h01, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd1};
    tbl[14] = '{1'b1, 1'b1, 5'h00, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd1};
    tbl[15] = '{1'b0, 1'b0, 5'h00, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd1};
    tbl[16] = '{1'b0, 1'b0, 5'h04, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'd1};

    rst_n   = 1'b0;
    strt    = 1'b0;
    abort   = 1'b0;
    stg_rdy = '0;
    tx_done = 1'b0;
    repeat (3) @(negedge clk);
    check_all("reset", 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
    rst_n = 1'b1;

    // ---- table-driven vectors -------------------------------------------
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].s, tbl[i].a, tbl[i].r, tbl[i].t);
      check_all($sformatf("v%0d", i), tbl[i].e_strt, tbl[i].e_bsy, tbl[i].e_done,
                tbl[i].e_tmo, tbl[i].e_spur, tbl[i].e_cur, tbl[i].e_frm);
    end

    // ---- nominal frame with 20-cycle stage latency ------------------------
    idle(10);
    step(1'b1, 1'b0, 5'd0, 1'b0);
    check_all("nom.start", 5'h01, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd1);
    for (int k = 0; k < NUM_STG; k++) begin
      logic [4:0] e_strt;
      for (int i = 0; i < 19; i++) begin
        idle(1);
        check($sformatf("nom.s%0d.gap", k), 32'(stg_strt), 32'd0);
      end
      step(1'b0, 1'b0, 5'(1 << k), 1'b0);
      e_strt = (k < NUM_STG - 1) ? 5'(1 << (k + 1)) : 5'd0;
      check($sformatf("nom.s%0d.next_strt", k), 32'(stg_strt), 32'(e_strt));
      check($sformatf("nom.s%0d.cur", k), 32'(cur_stg),
            (k < NUM_STG - 1) ? 32'(k + 1) : 32'(NUM_STG - 1));
    end
    idle(49);
    check_all("nom.wait_tx", 5'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 8'd1);
    step(1'b0, 1'b0, 5'd0, 1'b1);
    check_all("nom.done", 5'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd2);
    idle(1);
    check("nom.done_width", 32'(done), 32'd0);

    // ---- watchdog timeout on stage 2 -------------------------------------
    step(1'b1, 1'b0, 5'd0, 1'b0);
    step(1'b0, 1'b0, 5'h01, 1'b0);
    step(1'b0, 1'b0, 5'h02, 1'b0);
    check("tmo.strt2", 32'(stg_strt), 32'h04);
    for (int i = 1; i < TMO_CYC; i++) begin
      idle(1);
      check($sformatf("tmo.pre%0d", i), 32'(err_tmo), 32'd0);
    end
    idle(1);
    check_all("tmo.expire", 5'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 8'd2);
    idle(1);
    check_all("tmo.hold", 5'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 8'd2);
    step(1'b1, 1'b0, 5'd0, 1'b0);
    check_all("tmo.restart", 5'h01, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd2);
    step(1'b0, 1'b1, 5'd0, 1'b0);

    // ---- ready coincident with watchdog expiry ----------------------------
    step(1'b1, 1'b0, 5'd0, 1'b0);
    check("coin.strt0", 32'(stg_strt), 32'h01);
    idle(TMO_CYC - 1);
    check("coin.pre_tmo", 32'(err_tmo), 32'd0);
    step(1'b0, 1'b0, 5'h01, 1'b0);
    check_all("coin.rdy", 5'h02, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 8'd2);
    for (int k = 1; k < NUM_STG; k++) step(1'b0, 1'b0, 5'(1 << k), 1'b0);
    idle(TMO_CYC - 1);
    check("coin.tx_pre", 32'(bsy), 32'd1);
    step(1'b0, 1'b0, 5'd0, 1'b1);
    check_all("coin.tx", 5'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd3);

    // ---- abort during WAIT_TX ------------------------------------------
    fast_to_wait_tx();
    check("abt.bsy_pre", 32'(bsy), 32'd1);
    step(1'b0, 1'b1, 5'd0, 1'b0);
    check_all("abt.idle", 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd3);
    step(1'b0, 1'b0, 5'd0, 1'b1);
    check_all("abt.tx_ignored", 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd3);

    // ---- asynchronous reset mid-RUN --------------------------------------
    step(1'b1, 1'b0, 5'd0, 1'b0);
    step(1'b0, 1'b0, 5'h01, 1'b0);
    check("rst.pre_cur", 32'(cur_stg), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_all("rst.async", 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    check_all("rst.after", 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);

    // ---- 256 back-to-back frames: frame counter wraps -------------------
    for (int f = 0; f < 256; f++) begin
      fast_to_wait_tx();
      step(1'b0, 1'b0, 5'd0, 1'b1);
      check($sformatf("wrap.f%0d.done", f), 32'(done), 32'd1);
      check($sformatf("wrap.f%0d.cnt", f), 32'(frm_cnt), 32'((f + 1) % 256));
    end
    check("wrap.final", 32'(frm_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cnn_seq_ctrl.md
Name: cnn_seq_ctrl

Overview:
Top-level sequencer for the CNN layer pipeline (conv, max-pool, conv, max-pool, dense). It accepts one frame-start request and issues a one-cycle start pulse to each stage in order, advancing on that stage's ready pulse. It then waits for the result byte's tx_done, reports completion, and guards every stage with a watchdog timeout. It sits between the host/UART front end and the layer instances, replacing the direct rdy-to-strt chaining.

Parameters:
NUM_STG, 5, number of pipeline stages sequenced (2..8)
TMO_CYC, 1000000, watchdog limit in clk cycles per stage (and for the tx wait); must be >= 2
STG_W, 3, width of cur_stg; must satisfy 2^STG_W >= NUM_STG

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
strt  in  1  frame start request, single-cycle pulse from host
abort  in  1  synchronous abort; returns to IDLE
stg_rdy  in  NUM_STG  per-stage ready pulses (bit k = stage k finished)
tx_done  in  1  UART transmitter finished sending result byte
stg_strt  out  NUM_STG  per-stage start pulses, one-hot, single cycle
bsy  out  1  frame in progress
done  out  1  one-cycle pulse on frame completion
err_tmo  out  1  sticky watchdog-timeout flag
err_spur  out  1  sticky flag for a ready pulse from a non-current stage
cur_stg  out  STG_W  index of stage currently running
frm_cnt  out  8  completed-frame counter

Behaviour:
- Reset (rst_n low, async): state IDLE; stg_strt=0, bsy=0, done=0, err_tmo=0, err_spur=0, cur_stg=0, frm_cnt=0, watchdog=0.
- All outputs are registered; no combinational input-to-output paths.
- States: IDLE, RUN, WAIT_TX, ERR.
- IDLE: strt sampled high at edge N -> stg_strt[0]=1 during cycle N+1 only; state RUN, cur_stg=0, bsy=1, watchdog cleared. Clear err_spur on this transition.
- RUN: stg_rdy[cur_stg] sampled high at edge M:
  - If cur_stg<NUM_STG-1: stg_strt[cur_stg+1]=1 for cycle M+1; cur_stg increments; watchdog cleared.
  - If cur_stg=NUM_STG-1: go to WAIT_TX; watchdog cleared; no stg_strt.
- WAIT_TX: tx_done sampled high -> next cycle done=1 (one cycle), bsy=0, frm_cnt+1 (wraps 255->0), state IDLE, cur_stg=0.
- A tx_done outside WAIT_TX is ignored.
- Watchdog:
  - Counts every cycle in RUN and WAIT_TX.
  - On reaching TMO_CYC-1 without advance: state ERR, err_tmo=1, bsy=0, no done.
  - A ready/tx_done in the same cycle as expiry wins: advance, no error.
- ERR: holds cur_stg at the failing stage. strt clears err_tmo and starts a new frame exactly as from IDLE. abort -> IDLE with err_tmo still set.
- err_spur:
  - Set when any stg_rdy bit other than cur_stg is high during RUN, or any stg_rdy bit is high in IDLE or WAIT_TX.
  - Spurious pulses are otherwise ignored; a valid stg_rdy[cur_stg] in the same cycle is still honoured.
- strt while bsy=1 is ignored; no restart, no flag.
- abort (any state except reset): next cycle state IDLE, bsy=0, cur_stg=0, stg_strt=0, watchdog=0, no done, frm_cnt unchanged.
- abort and strt in the same cycle: abort wins.
- Reset mid-frame: all state returns immediately to reset values; no pulses emitted.
- At most one stg_strt bit is high in any cycle; each is exactly one cycle wide.

Test Plan:
- Nominal frame, NUM_STG=5: strt at cycle 10, each stg_rdy[k] returned 20 cycles after its stg_strt[k], tx_done 50 cycles after stg_rdy[4] -> stg_strt[0..4] single-cycle one-hot at the expected edges, done one cycle after tx_done, frm_cnt=1, bsy low with done.
- Timeout, TMO_CYC=100: strt, withhold stg_rdy[2] -> err_tmo=1 and bsy=0 exactly 100 cycles after stg_strt[2]'s edge, cur_stg=2, no done. Then strt -> err_tmo clears, stg_strt[0] pulses.
- Spurious and overlap: during stage 1, pulse stg_rdy[3] -> err_spur=1, stage unchanged. In the same cycle as stg_rdy[1], assert strt -> strt ignored, stg_strt[2] pulses. Next frame's start clears err_spur.
- Abort and reset: abort during WAIT_TX -> IDLE next cycle, no done, frm_cnt unchanged. rst_n low mid-RUN -> all outputs 0 immediately. abort+strt same cycle in IDLE -> stays IDLE.
- Boundaries:
  - 256 back-to-back frames -> frm_cnt wraps to 0.
  - stg_rdy coincident with watchdog expiry (TMO_CYC=100, ready at cycle 99) -> advance, err_tmo=0.
  - tx_done pulsed in IDLE -> ignored.
